// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit.
// FETCH_PERF_CNT_EN (a define) adds the retired-instruction counter to pc_fetch_unit.
package pc_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetchState_t;

  localparam int INSTR_W = 32;
  localparam int JUMP_W  = 26;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_pc_next.sv
// Next-PC selection: jump beats branch, branch beats sequential. Purely combinational.
module pc_next
  import pc_fetch_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] PC,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [INSTR_W-1:0] SignImm,
  input  logic               PCSrc,
  input  logic               Jump,
  output logic [INSTR_W-1:0] nextPc
);

  logic [INSTR_W-1:0] pcPlus4;
  logic [INSTR_W-1:0] branchTarget;
  logic [INSTR_W-1:0] jumpTarget;
  logic               unusedBits;

  assign pcPlus4      = PC + 32'd4;
  // The word offset is scaled to bytes; its top two bits fall off the 32-bit sum.
  assign branchTarget = pcPlus4 + {SignImm[INSTR_W-3:0], 2'b00};
  assign jumpTarget   = {pcPlus4[INSTR_W-1:INSTR_W-4], Instr[JUMP_W-1:0], 2'b00};
  assign unusedBits   = ^{Instr[INSTR_W-1:JUMP_W], SignImm[INSTR_W-1:INSTR_W-2]};

  always_comb begin
    nextPc = pcPlus4;
    if (Jump) begin
      nextPc = jumpTarget;
    end else if (PCSrc) begin
      nextPc = branchTarget;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Two-state fetch sequencer: requests an instruction, holds it until the datapath retires it.
// Define FETCH_PERF_CNT_EN to add the 32-bit instret counter output.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic [31:0] SignImm,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] instret,
`endif
  output logic        stateDbg
);

  // Handshakes: imem_req/imem_addr are held until a cycle with imem_ack, which completes
  // the transfer in that cycle; Instr/PC are held with InstrValid until a cycle with
  // retire. Each side ignores its handshake input while the other state is active.

  fetchState_t        state;
  fetchState_t        stateNext;
  logic [31:0]        pcReg;
  logic [31:0]        instrReg;
  logic [31:0]        nextPc;
  logic               loadInstr;
  logic               loadPc;

  pc_next uPcNext (
    .PC      (pcReg),
    .Instr   (instrReg),
    .SignImm (SignImm),
    .PCSrc   (PCSrc),
    .Jump    (Jump),
    .nextPc  (nextPc)
  );

  always_comb begin
    stateNext = state;
    loadInstr = 1'b0;
    loadPc    = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          loadInstr = 1'b1;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          loadPc    = 1'b1;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pcReg    <= RESET_PC;
      instrReg <= '0;
    end else begin
      state <= stateNext;
      if (loadInstr) instrReg <= imem_rdata;
      if (loadPc)    pcReg    <= nextPc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instretReg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instretReg <= '0;
    end else if (loadPc) begin
      instretReg <= instretReg + 32'd1;
    end
  end

  assign instret = instretReg;
`endif

  // Gating with rst_n keeps the request low for the whole reset, not just after the edge.
  assign imem_req   = rst_n && (state == FETCH);
  assign imem_addr  = pcReg;
  assign Instr      = instrReg;
  assign InstrValid = (state == EXEC);
  assign PC         = pcReg;
  assign PCPlus4    = pcReg + 32'd4;
  assign stateDbg   = state;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port PCSrc  input  1  branch taken, from controller.
REQ-005 SHALL have port Jump  input  1  jump, from controller.
REQ-006 SHALL have port SignImm  input  32  sign-extended branch offset, in words.
REQ-007 SHALL have port retire  input  1  datapath finished current instruction.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request.
REQ-009 SHALL have port imem_addr  output  32  fetch address.
REQ-010 SHALL have port imem_ack  input  1  read data valid.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port Instr  output  32  held instruction.
REQ-013 SHALL have port InstrValid  output  1  Instr valid for decode.
REQ-014 SHALL have port PC  output  32  address of held instruction.
REQ-015 SHALL have port PCPlus4  output  32  PC+4, modulo 2^32.

Function
REQ-016 SHALL implement FSM states FETCH and EXEC.
REQ-017 FETCH: imem_req=1 and imem_addr=PC; both SHALL stay stable until imem_ack.
REQ-018 FETCH with imem_ack=1 (including the first cycle of FETCH) SHALL latch imem_rdata into Instr and go to EXEC next cycle.
REQ-019 EXEC: imem_req=0, InstrValid=1; Instr and PC SHALL stay stable until retire.
REQ-020 EXEC with retire=1 SHALL load the next PC and go to FETCH next cycle.
REQ-021 Next PC priority SHALL be: Jump -> {PCPlus4[31:28], Instr[25:0], 2'b00}; else PCSrc -> PCPlus4 + (SignImm<<2); else PCPlus4.
REQ-022 Jump=1 and PCSrc=1 together SHALL select the jump target.
REQ-023 All address arithmetic SHALL be 32-bit, with wrap-around; PC 32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-024 retire SHALL be ignored in FETCH; imem_ack SHALL be ignored in EXEC.
REQ-025 PCSrc, Jump and SignImm SHALL be sampled only in the EXEC cycle where retire=1.
REQ-026 Minimum retire-to-retire latency SHALL be 2 cycles, i.e. 1-cycle memory ack plus 1 EXEC cycle.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set state=FETCH, PC=RESET_PC, Instr=0, InstrValid=0 and the counter (REQ-031) to 0.
REQ-028 During reset, imem_req SHALL be 0.
REQ-029 An outstanding fetch SHALL be abandoned on reset; an imem_ack arriving in a reset cycle SHALL be discarded.
REQ-030 On the first cycle after release, imem_req SHALL be 1 with imem_addr=RESET_PC.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined, the block SHALL add output instret (32 bits), incremented on each accepted retire and wrapping at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN, instret SHALL be absent and no counter logic SHALL be synthesised; all other behaviour SHALL be identical.

Structure
REQ-033 A shared package SHALL hold the state enum, INSTR_W=32, the jump-field width 26 and the default RESET_PC.
REQ-034 Next-PC selection SHALL live in one combinational sub-module, pc_next (inputs PC, Instr, SignImm, PCSrc, Jump; output next PC).

Verification
REQ-035 Reset then ack after 3 cycles with rdata 32'h2008_0005 -> imem_addr=0 throughout; Instr=32'h2008_0005 and InstrValid=1 on the cycle after ack.
REQ-036 PC=32'h0000_0040, retire with PCSrc=1 and SignImm=32'hFFFF_FFFE -> next imem_addr=32'h0000_003C.
REQ-037 PC=32'h1000_0008, Instr=32'h0800_0010, Jump=1 and PCSrc=1 -> next imem_addr=32'h1000_0040.
REQ-038 RESET_PC=32'hFFFF_FFFC, retire with no branch -> next imem_addr=0 and PCPlus4 wraps correctly.
REQ-039 rst_n low during FETCH with ack in the same cycle -> Instr stays 0 and the fetch restarts at RESET_PC; in EXEC, retire pulses are ignored while held.
REQ-040 With FETCH_PERF_CNT_EN, 5 retires -> instret=5, and retire asserted in FETCH does not count.
